interp_row_padder: RTL and testbench

//   Upstream feeder for the 8-tap quarter-pel luma interpolator. Buffers one row (or column) of

---
 rtl/interp_row_padder.sv | 224 ++++++++++++++++++++++
 tb/tb_interp_row_padder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_row_padder.sv
// interp_row_padder
//   Ping-pong row buffer feeding the 8-tap quarter-pel luma interpolator.
//   One bank fills from the upstream handshake while the other streams an
//   edge-padded row (3 left replicas, WIDTH body pixels, 4 right replicas)
//   with no gaps between back-to-back rows. A marker travels an 8-stage
//   delay line next to the stream and flags the cycles where the
//   interpolator's a/b/c sums belong to output pixel win_idx.
//
//   state | meaning
//   IDLE  | nothing streaming; waiting for the read bank to become full
//   LPAD  | emitting the left replicas of pixel 0 (3 cycles)
//   BODY  | emitting pixels 0..WIDTH-1 of the read bank
//   RPAD  | emitting the right replicas of pixel WIDTH-1 (4 cycles)
module interp_row_padder #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               in_pix,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               pix_out,
    output logic                     pix_valid,
    output logic                     win_valid,
    output logic [$clog2(WIDTH)-1:0] win_idx,
    output logic                     win_row_last,
    output logic                     win_frame_last
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    // Phase timers load "cycles remaining minus one" and end at zero.
    localparam logic [IDX_W-1:0] LPAD_LOAD = IDX_W'(2);
    localparam logic [IDX_W-1:0] RPAD_LOAD = IDX_W'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LPAD = 2'd1,
        S_BODY = 2'd2,
        S_RPAD = 2'd3
    } state_t;

    logic [7:0]       bank_mem [2][WIDTH];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] phase_cnt;
    state_t           state;

    logic             mark_on;
    logic [IDX_W-1:0] mark_idx;
    logic [7:0]       dly_valid;
    logic [IDX_W-1:0] dly_idx [8];
    logic [ROW_W-1:0] row_cnt;

    logic             xfer;
    logic             fill_done;
    logic             row_done;
    logic             other_full;

    assign in_ready   = reset_n & ~full[wr_bank];
    assign xfer       = in_valid & in_ready;
    assign fill_done  = xfer & (wr_ptr == LAST_IDX);
    assign row_done   = (state == S_RPAD) && (phase_cnt == '0);
    assign other_full = full[~rd_bank];

    assign win_valid  = dly_valid[7];
    assign win_idx    = dly_idx[7];

    // Pixel storage: accepted pixels land in the bank currently being filled
    always_ff @(posedge clock) begin
        if (xfer) begin
            bank_mem[wr_bank][wr_ptr] <= in_pix;
        end
    end

    // Fill pointer, bank selection and full flags; a fill and a free on the
    // same edge always touch different banks, so both are applied
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
        end else begin
            if (xfer) begin
                if (fill_done) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr  <= wr_ptr + 1'b1;
                end
            end
            if (fill_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (row_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Emit FSM: registered pix_out/pix_valid describe the current stream
    // position; the row-start marker is raised on the edge entering LPAD
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            rd_ptr    <= '0;
            rd_bank   <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            mark_on   <= 1'b0;
            mark_idx  <= '0;
        end else begin
            if (mark_on) begin
                if (mark_idx == LAST_IDX) begin
                    mark_on <= 1'b0;
                end else begin
                    mark_idx <= mark_idx + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (full[rd_bank]) begin
                        state     <= S_LPAD;
                        phase_cnt <= LPAD_LOAD;
                        pix_out   <= bank_mem[rd_bank][0];
                        pix_valid <= 1'b1;
                        mark_on   <= 1'b1;
                        mark_idx  <= '0;
                    end
                end

                S_LPAD: begin
                    pix_out <= bank_mem[rd_bank][0];
                    if (phase_cnt == '0) begin
                        state     <= S_BODY;
                        phase_cnt <= LAST_IDX;
                        rd_ptr    <= IDX_W'(1);
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                S_BODY: begin
                    if (phase_cnt == '0) begin
                        state     <= S_RPAD;
                        phase_cnt <= RPAD_LOAD;
                        pix_out   <= bank_mem[rd_bank][LAST_IDX];
                    end else begin
                        pix_out   <= bank_mem[rd_bank][rd_ptr];
                        rd_ptr    <= rd_ptr + 1'b1;
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                S_RPAD: begin
                    if (phase_cnt == '0) begin
                        rd_bank <= ~rd_bank;
                        if (other_full) begin
                            state     <= S_LPAD;
                            phase_cnt <= LPAD_LOAD;
                            pix_out   <= bank_mem[~rd_bank][0];
                            mark_on   <= 1'b1;
                            mark_idx  <= '0;
                        end else begin
                            state     <= S_IDLE;
                            pix_valid <= 1'b0;
                        end
                    end else begin
                        pix_out   <= bank_mem[rd_bank][LAST_IDX];
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

    // Delay the per-pixel markers by eight cycles: by then the interpolator
    // buffer holds padded p(j-3)..p(j+4) for marker j
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dly_valid <= '0;
            for (int i = 0; i < 8; i++) begin
                dly_idx[i] <= '0;
            end
        end else begin
            dly_valid  <= {dly_valid[6:0], mark_on};
            dly_idx[0] <= mark_idx;
            for (int i = 1; i < 8; i++) begin
                dly_idx[i] <= dly_idx[i-1];
            end
        end
    end

    // Row/frame end flags track the last delay stage; the row counter
    // advances after each row end and wraps after the frame end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            win_row_last   <= 1'b0;
            win_frame_last <= 1'b0;
            row_cnt        <= '0;
        end else begin
            win_row_last   <= dly_valid[6] && (dly_idx[6] == LAST_IDX);
            win_frame_last <= dly_valid[6] && (dly_idx[6] == LAST_IDX) &&
                              (row_cnt == LAST_ROW);
            if (win_row_last) begin
                row_cnt <= win_frame_last ? '0 : row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interp_row_padder.sv
// Bench for interp_row_padder: a queue-based model of rows, padded streams
// and window timing, plus an attached model of the 8-tap interpolator.
module tb_interp_row_padder;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int IW = $clog2(W);

    typedef logic [W*8-1:0] row_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    in_pix = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    pix_out;
    logic          pix_valid;
    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic          win_row_last;
    logic          win_frame_last;

    interp_row_padder #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_pix         (in_pix),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pix_out        (pix_out),
        .pix_valid      (pix_valid),
        .win_valid      (win_valid),
        .win_idx        (win_idx),
        .win_row_last   (win_row_last),
        .win_frame_last (win_frame_last)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // interpolator filter taps, index k applies to padded p(j-3+k)
    int ca[8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    int cb[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    int cc[8] = '{0, 1, -5, 17, 58, -10, 4, -1};

    function automatic int padpix(input row_t r, input int p);
        int k;
        k = (p < 0) ? 0 : ((p > W - 1) ? W - 1 : p);
        return int'(r[k*8 +: 8]);
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];
    row_t       full_q[$];
    row_t       part;
    int         part_n = 0;
    bit         m_active = 0;
    int         m_pos = 0;
    logic [7:0] m_pix = 8'd0;
    int         cyc = 0;
    int         win_start[$];
    row_t       win_row[$];
    bit         e_wv = 0, e_rl = 0, e_fl = 0;
    int         e_idx = 0, e_a = 0, e_b = 0, e_c = 0;
    int         m_rowno = 0;
    bit         model_on = 0;
    bit         m_xfer;
    int         epoch = 0;
    int         m_epoch = 0;
    int         xfer_cnt = 0;
    int         m_starts = 0;

    always @(posedge clock) begin
        if (epoch != m_epoch) begin
            m_epoch  = epoch;
            xfer_cnt = 0;
            m_starts = 0;
        end
        m_xfer = reset_n && in_valid && (full_q.size() < 2);
        cyc++;
        if (!reset_n) begin
            full_q.delete();
            part_n   = 0;
            m_active = 0;
            m_pos    = 0;
            m_pix    = 8'd0;
            win_start.delete();
            win_row.delete();
            m_rowno  = 0;
            e_wv = 0; e_rl = 0; e_fl = 0; e_idx = 0;
            model_on = 1;
        end else begin
            if (e_rl) m_rowno = e_fl ? 0 : m_rowno + 1;
            // stream: a bank filled on this same edge is not yet visible
            if (m_active) begin
                if (m_pos == W + 6) begin
                    void'(full_q.pop_front());
                    if (full_q.size() > 0) m_pos = 0;
                    else m_active = 0;
                end else begin
                    m_pos++;
                end
            end else if (full_q.size() > 0) begin
                m_active = 1;
                m_pos    = 0;
            end
            if (m_active) begin
                m_pix = 8'(padpix(full_q[0], m_pos - 3));
                if (m_pos == 0) begin
                    win_start.push_back(cyc);
                    win_row.push_back(full_q[0]);
                    m_starts++;
                end
            end
            // fill
            if (m_xfer) begin
                part[part_n*8 +: 8] = in_pix;
                part_n++;
                xfer_cnt++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                if (part_n == W) begin
                    full_q.push_back(part);
                    part_n = 0;
                end
            end
            // windows: pixel j of a row started at t0 is valid at t0+8+j
            while (win_start.size() > 0 && cyc > win_start[0] + 7 + W) begin
                void'(win_start.pop_front());
                void'(win_row.pop_front());
            end
            e_wv = 0; e_rl = 0; e_fl = 0;
            if (win_start.size() > 0 && cyc >= win_start[0] + 8) begin
                e_wv  = 1;
                e_idx = cyc - win_start[0] - 8;
                e_rl  = (e_idx == W - 1);
                e_fl  = e_rl && (m_rowno == H - 1);
                e_a = 0; e_b = 0; e_c = 0;
                for (int k = 0; k < 8; k++) begin
                    e_a += ca[k] * padpix(win_row[0], e_idx - 3 + k);
                    e_b += cb[k] * padpix(win_row[0], e_idx - 3 + k);
                    e_c += cc[k] * padpix(win_row[0], e_idx - 3 + k);
                end
            end
        end
    end

    // attached interpolator: shifts pix_out every clock, ibuf[7] is oldest
    logic [7:0] ibuf [8];
    always @(posedge clock) begin
        for (int k = 7; k > 0; k--) ibuf[k] <= ibuf[k-1];
        ibuf[0] <= pix_out;
    end

    // ---------------- compare + statistics ----------------
    int a_act, b_act, c_act;
    int s_epoch = 0;
    int pv_run = 0, max_run = 0, wv_cnt = 0, rl_cnt = 0, fl_cnt = 0;
    int fl_row = -1, a0 = -1, const_cnt = 0, first_drop = -1;
    int pv_log[$];

    always @(negedge clock) begin
        if (s_epoch != epoch) begin
            s_epoch = epoch;
            pv_run = 0; max_run = 0; wv_cnt = 0; rl_cnt = 0; fl_cnt = 0;
            fl_row = -1; a0 = -1; const_cnt = 0; first_drop = -1;
            pv_log.delete();
        end
        if (model_on) begin
            a_act = 0; b_act = 0; c_act = 0;
            for (int k = 0; k < 8; k++) begin
                a_act += ca[k] * int'(ibuf[7-k]);
                b_act += cb[k] * int'(ibuf[7-k]);
                c_act += cc[k] * int'(ibuf[7-k]);
            end
            chk("in_ready", int'(in_ready), int'(reset_n && (full_q.size() < 2)));
            chk("pix_valid", int'(pix_valid), int'(m_active));
            chk("pix_out", int'(pix_out), int'(m_pix));
            chk("win_valid", int'(win_valid), int'(e_wv));
            chk("win_row_last", int'(win_row_last), int'(e_rl));
            chk("win_frame_last", int'(win_frame_last), int'(e_fl));
            if (e_wv) begin
                chk("win_idx", int'(win_idx), e_idx);
                chk("a_sum", a_act, e_a);
                chk("b_sum", b_act, e_b);
                chk("c_sum", c_act, e_c);
            end
            if (pix_valid) begin
                pv_run++;
                pv_log.push_back(int'(pix_out));
                if (pv_run > max_run) max_run = pv_run;
            end else begin
                pv_run = 0;
            end
            if (win_valid) begin
                wv_cnt++;
                if (win_idx == 0) a0 = a_act;
                if (a_act == 6400 && b_act == 6400 && c_act == 6400) const_cnt++;
            end
            if (win_frame_last) begin
                fl_cnt++;
                fl_row = rl_cnt;
            end
            if (win_row_last) rl_cnt++;
            if (reset_n && !in_ready && first_drop < 0) first_drop = xfer_cnt;
        end
    end

    // ---------------- stimulus ----------------
    int  gap_pct = 0;
    bit  force_valid = 0;

    task automatic step();
        @(posedge clock);
        #2;
        if (tx_q.size() > 0 && (gap_pct == 0 || int'($urandom_range(99)) >= gap_pct)) begin
            in_valid = 1'b1;
            in_pix   = tx_q[0];
        end else begin
            in_valid = force_valid;
            in_pix   = 8'($urandom);
        end
    endtask

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while (!(tx_q.size() == 0 && !m_active && full_q.size() == 0 &&
                 part_n == 0 && win_start.size() == 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: drain timeout after %0d cycles, expected idle", nm, n);
        end
        step();
        step();
    endtask

    task automatic push_ramp();
        for (int j = 0; j < W; j++) tx_q.push_back(8'((j * 127 + 7) / (W - 1)));
    endtask

    task automatic push_random_rows(input int n);
        for (int i = 0; i < n * W; i++) tx_q.push_back(8'($urandom));
    endtask

    initial begin
        int n;
        // 1: reset held with in_valid high
        force_valid = 1;
        reset_n = 1'b0;
        in_valid = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_win_idx", int'(win_idx), 0);
        force_valid = 0;
        in_valid = 1'b0;
        reset_n = 1'b1;
        repeat (4) step();
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_pix_valid", int'(pix_valid), 0);

        // 2: ramp row
        epoch++;
        gap_pct = 30;
        push_ramp();
        drain(400, "ramp");
        chk("ramp_len", pv_log.size(), 23);
        if (pv_log.size() == 23) begin
            chk("ramp_p0", pv_log[0], 0);
            chk("ramp_p4", pv_log[4], 8);
            chk("ramp_p5", pv_log[5], 17);
            chk("ramp_p22", pv_log[22], 127);
        end
        chk("ramp_a_j0", a0, 76);
        chk("ramp_wv_cnt", wv_cnt, 16);

        // 3: constant row of 100
        epoch++;
        for (int j = 0; j < W; j++) tx_q.push_back(8'd100);
        drain(400, "const");
        chk("const_abc_6400", const_cnt, 16);
        chk("const_row_last", rl_cnt, 1);

        // 4: three rows back to back
        epoch++;
        gap_pct = 0;
        push_random_rows(3);
        drain(400, "b2b");
        chk("b2b_ready_drop", first_drop, 32);
        chk("b2b_pv_run", max_run, 69);
        chk("b2b_wv_cnt", wv_cnt, 48);
        chk("b2b_row_last", rl_cnt, 3);

        // 5: frame of 16 rows plus one, from a fresh row count
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        epoch++;
        gap_pct = 20;
        push_random_rows(H + 1);
        drain(3000, "frame");
        chk("frame_last_cnt", fl_cnt, 1);
        chk("frame_last_row", fl_row, H - 1);
        chk("frame_row_last", rl_cnt, H + 1);

        // 6: reset during BODY of row 1, then a fresh ramp row
        epoch++;
        gap_pct = 0;
        push_random_rows(2);
        n = 0;
        while (!(m_starts == 2 && m_active && m_pos == 6) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL midrow_wait: row 1 body not reached in %0d cycles", n);
        end
        tx_q.delete();
        in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrow_win_valid", int'(win_valid), 0);
        chk("midrow_pix_valid", int'(pix_valid), 0);
        step();
        epoch++;
        gap_pct = 25;
        push_ramp();
        drain(400, "midrow_ramp");
        chk("midrow_ramp_len", pv_log.size(), 23);
        chk("midrow_ramp_a_j0", a0, 76);
        chk("midrow_ramp_wv_cnt", wv_cnt, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
